// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder built from 1-bit full-adder cells.
// sum/cout are purely combinational. When REG_OUT is set, sum_q, cout_q and
// ovf_q hold the previous edge's result with a synchronous active-high reset.
// When REG_OUT is clear, the registered outputs are tied low and no flops exist.
module full_adder #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             cout,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q
);

    // One full-adder cell: returns {carry_out, sum_bit}. Plain bitwise
    // operators are used so that X/Z on any input propagates to the outputs.
    function automatic logic [1:0] fa_cell(input logic ai, input logic bi, input logic ci);
        logic s_v;
        logic c_v;
        s_v = ai ^ bi ^ ci;
        c_v = (ai & bi) | (ai & ci) | (bi & ci);
        fa_cell = {c_v, s_v};
    endfunction

    // carry_s[i] is the carry into bit i; carry_s[WIDTH] is the carry-out.
    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    logic             ovf_s;

    // Ripple chain: the carry of each cell feeds the next cell up.
    always_comb begin
        carry_s    = {(WIDTH+1){1'b0}};
        sum_s      = {WIDTH{1'b0}};
        carry_s[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            {carry_s[i+1], sum_s[i]} = fa_cell(a[i], b[i], carry_s[i]);
        end
    end

    // Signed overflow: the carry into the sign bit differs from the carry out.
    // For WIDTH=1 this is cout ^ cin, since carry_s[0] is cin.
    assign ovf_s = carry_s[WIDTH] ^ carry_s[WIDTH-1];

    assign sum  = sum_s;
    assign cout = carry_s[WIDTH];

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] sum_d;
            logic             cout_d;
            logic             ovf_d;

            // Next-state values for the output registers.
            always_comb begin
                sum_d  = sum_s;
                cout_d = carry_s[WIDTH];
                ovf_d  = ovf_s;
            end

            // Output registers; reset takes priority over the load.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_q  <= {WIDTH{1'b0}};
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else begin
                    sum_q  <= sum_d;
                    cout_q <= cout_d;
                    ovf_q  <= ovf_d;
                end
            end
        end else begin : g_noreg
            // Clock, reset and the overflow term have no load without the
            // registers; collect them so they read as intentionally unused.
            logic unused_ok_s;
            assign unused_ok_s = ^{clk, rst, ovf_s};

            assign sum_q  = {WIDTH{1'b0}};
            assign cout_q = 1'b0;
            assign ovf_q  = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: scoreboard bench for full_adder at WIDTH 1, 8 and 16.
// Combinational results are compared right after the inputs settle; the
// matching registered results are pushed to a queue and compared one cycle
// later against the registered outputs.
module tb_full_adder;

    typedef struct {
        int          dut;
        logic [63:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut 0 : WIDTH=1,  REG_OUT=1 (u1), shares inputs with u1n (REG_OUT=0)
    // dut 1 : WIDTH=8,  REG_OUT=1 (u8)
    // dut 2 : WIDTH=16, REG_OUT=1 (u16)
    logic        rst1 = 1'b1, rst8 = 1'b1, rst16 = 1'b1;
    logic        a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic        ci8 = 1'b0;
    logic [15:0] a16 = 16'd0, b16 = 16'd0;
    logic        ci16 = 1'b0;

    logic        cout1, sum1, sumq1, coutq1, ovfq1;
    logic        cout1n, sum1n, sumq1n, coutq1n, ovfq1n;
    logic        cout8, coutq8, ovfq8;
    logic [7:0]  sum8, sumq8;
    logic        cout16, coutq16, ovfq16;
    logic [15:0] sum16, sumq16;

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
        .clk(clk), .rst(rst1), .a(a1), .b(b1), .cin(ci1),
        .cout(cout1), .sum(sum1), .sum_q(sumq1), .cout_q(coutq1), .ovf_q(ovfq1));

    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u1n (
        .clk(clk), .rst(rst1), .a(a1), .b(b1), .cin(ci1),
        .cout(cout1n), .sum(sum1n), .sum_q(sumq1n), .cout_q(coutq1n), .ovf_q(ovfq1n));

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u8 (
        .clk(clk), .rst(rst8), .a(a8), .b(b8), .cin(ci8),
        .cout(cout8), .sum(sum8), .sum_q(sumq8), .cout_q(coutq8), .ovf_q(ovfq8));

    full_adder #(.WIDTH(16), .REG_OUT(1'b1)) u16 (
        .clk(clk), .rst(rst16), .a(a16), .b(b16), .cin(ci16),
        .cout(cout16), .sum(sum16), .sum_q(sumq16), .cout_q(coutq16), .ovf_q(ovfq16));

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer addition; overflow from operand/result sign bits.
    task automatic model(input int w, input logic [63:0] av, input logic [63:0] bv, input logic cv,
                         output logic [63:0] s, output logic co, output logic ov);
        logic [64:0] t;
        logic [63:0] mask;
        t    = {1'b0, av} + {1'b0, bv} + {64'd0, cv};
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        s    = t[63:0] & mask;
        co   = t[w];
        ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    endtask

    function automatic int width_of(input int dut);
        case (dut)
            0: width_of = 1;
            1: width_of = 8;
            default: width_of = 16;
        endcase
    endfunction

    task automatic pop_and_check();
        exp_t e;
        logic [63:0] sq;
        logic cq, oq;
        e = sb_q.pop_front();
        case (e.dut)
            0: begin sq = {63'd0, sumq1}; cq = coutq1; oq = ovfq1; end
            1: begin sq = {56'd0, sumq8}; cq = coutq8; oq = ovfq8; end
            default: begin sq = {48'd0, sumq16}; cq = coutq16; oq = ovfq16; end
        endcase
        check_val("sum_q",  sq, e.s);
        check_val("cout_q", {63'd0, cq}, {63'd0, e.co});
        check_val("ovf_q",  {63'd0, oq}, {63'd0, e.ov});
    endtask

    // Drive one vector at a falling edge, check comb outputs, queue the
    // registered expectation; the previous pending entry is checked first.
    task automatic apply_vec(input int dut, input logic [63:0] av, input logic [63:0] bv, input logic cv);
        exp_t e;
        logic [63:0] s_obs;
        logic co_obs;
        @(negedge clk);
        if (sb_q.size() > 0) pop_and_check();
        e.dut = dut;
        model(width_of(dut), av, bv, cv, e.s, e.co, e.ov);
        case (dut)
            0: begin a1 = av[0]; b1 = bv[0]; ci1 = cv; end
            1: begin a8 = av[7:0]; b8 = bv[7:0]; ci8 = cv; end
            default: begin a16 = av[15:0]; b16 = bv[15:0]; ci16 = cv; end
        endcase
        #1;
        case (dut)
            0: begin s_obs = {63'd0, sum1}; co_obs = cout1; end
            1: begin s_obs = {56'd0, sum8}; co_obs = cout8; end
            default: begin s_obs = {48'd0, sum16}; co_obs = cout16; end
        endcase
        check_val("sum",  s_obs, e.s);
        check_val("cout", {63'd0, co_obs}, {63'd0, e.co});
        if (dut == 0) begin
            check_val("noreg_sum",  {63'd0, sum1n},  e.s);
            check_val("noreg_cout", {63'd0, cout1n}, {63'd0, e.co});
            check_val("noreg_regs", {61'd0, sumq1n, coutq1n, ovfq1n}, 64'd0);
        end
        sb_q.push_back(e);
    endtask

    task automatic flush();
        @(negedge clk);
        while (sb_q.size() > 0) pop_and_check();
    endtask

    initial begin
        logic [1:0] tt_exp [8];
        tt_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_val("rst_u1",  {61'd0, sumq1, coutq1, ovfq1}, 64'd0);
        check_val("rst_u8",  {54'd0, sumq8, coutq8, ovfq8}, 64'd0);
        check_val("rst_u16", {46'd0, sumq16, coutq16, ovfq16}, 64'd0);
        rst1 = 1'b0; rst8 = 1'b0; rst16 = 1'b0;

        // WIDTH=1 truth table, one vector per 50 time units
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            apply_vec(0, {63'd0, v[2]}, {63'd0, v[1]}, v[0]);
            check_val("truth_table", {62'd0, cout1, sum1}, {62'd0, tt_exp[i]});
            repeat (4) @(negedge clk);
        end
        flush();

        // WIDTH=1: 1+1+0 -> sum_q=0, cout_q=1, ovf_q=1
        apply_vec(0, 64'd1, 64'd1, 1'b0);
        flush();

        // WIDTH=8 cases and boundaries
        apply_vec(1, 64'hFF, 64'h01, 1'b0);
        check_val("ff_plus_1_sum", {56'd0, sum8}, 64'h00);
        apply_vec(1, 64'h7F, 64'h00, 1'b1);
        check_val("7f_cin_sum", {56'd0, sum8}, 64'h80);
        apply_vec(1, 64'hFF, 64'hFF, 1'b1);
        apply_vec(1, 64'h00, 64'h00, 1'b0);
        apply_vec(1, 64'h80, 64'h80, 1'b0);
        apply_vec(2, 64'hFFFF, 64'hFFFF, 1'b1);
        apply_vec(2, 64'h0000, 64'h0000, 1'b0);
        flush();

        // Reset with priority over load, while the inputs change
        apply_vec(0, 64'd1, 64'd0, 1'b0);
        @(negedge clk);
        pop_and_check();
        rst1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        #1;
        check_val("rst_sum",  {63'd0, sum1},  64'd1);
        check_val("rst_cout", {63'd0, cout1}, 64'd1);
        @(negedge clk);
        check_val("rst_regs",      {61'd0, sumq1, coutq1, ovfq1}, 64'd0);
        check_val("rst_sum_hold",  {62'd0, cout1, sum1}, 64'd3);
        rst1 = 1'b0;
        @(negedge clk);
        check_val("post_rst_regs", {61'd0, sumq1, coutq1, ovfq1}, 64'd6);

        // Randomised WIDTH=16 vectors
        for (int i = 0; i < 1000; i++) begin
            apply_vec(2, {48'd0, 16'($urandom_range(0, 65535))},
                         {48'd0, 16'($urandom_range(0, 65535))},
                         1'($urandom_range(0, 1)));
        end
        flush();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter: WIDTH, default 1, operand width in bits (legal range 1..64).
REQ-002 Parameter: REG_OUT, default 0. When 1, the registered outputs are driven; when 0, they are tied to 0 and no flops are inferred.
REQ-003 Port: clk, input, 1 bit, single clock; all flops update on the rising edge.
REQ-004 Port: rst, input, 1 bit, reset; synchronous and active-high.
REQ-005 Port: a, input, WIDTH bits, addend A (unsigned).
REQ-006 Port: b, input, WIDTH bits, addend B (unsigned).
REQ-007 Port: cin, input, 1 bit, carry-in.
REQ-008 Port: cout, output, 1 bit, combinational carry-out.
REQ-009 Port: sum, output, WIDTH bits, combinational sum.
REQ-010 Port: sum_q, output, WIDTH bits, registered copy of sum.
REQ-011 Port: cout_q, output, 1 bit, registered copy of cout.
REQ-012 Port: ovf_q, output, 1 bit, registered signed-overflow flag.
REQ-013 Port order for instantiation: clk, rst, a, b, cin, cout, sum, sum_q, cout_q, ovf_q.

Function
REQ-014 {cout, sum} SHALL equal a + b + cin, computed at WIDTH+1 bits with no truncation of the carry.
REQ-015 sum and cout SHALL be purely combinational, with zero-cycle latency and no dependence on clk or rst.
REQ-016 Structure: a ripple chain of WIDTH 1-bit cells.
- Each cell computes s = a_i ^ b_i ^ c_i and c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i.
- c_0 = cin; cout = c_WIDTH.
REQ-017 For WIDTH=1 the truth table SHALL be:
- sum = a ^ b ^ cin
- cout = majority(a, b, cin)
REQ-018 Any X/Z on an input SHALL NOT be masked; outputs may propagate X.
REQ-019 When REG_OUT=1, each rising clk edge with rst=0 SHALL load sum_q <= sum and cout_q <= cout. Latency is exactly 1 cycle.
REQ-020 ovf_q SHALL load c_WIDTH ^ c_(WIDTH-1), the two's-complement overflow. For WIDTH=1 it loads cout ^ cin.
REQ-021 Inputs that change between clock edges SHALL affect only the combinational outputs until the next edge.
REQ-022 Boundary behaviour:
- All-ones + all-ones + cin=1 SHALL give sum = all-ones and cout = 1.
- All-zero + all-zero + cin=0 SHALL give sum = 0 and cout = 0.

Reset
REQ-023 When rst=1 at a rising clk edge, sum_q, cout_q and ovf_q SHALL become 0 on that edge.
REQ-024 Reset SHALL have priority over the load in REQ-019.
REQ-025 rst SHALL NOT affect sum or cout.
REQ-026 Before the first reset edge, the registered outputs are undefined; the bench SHALL NOT check them.
REQ-027 Deasserting rst SHALL resume loading on the next edge, with no extra bubble cycle.

Verification
REQ-028 WIDTH=1, apply all 8 {a,b,cin} combinations from 000 to 111, one per 50 time units.
- Required {cout,sum}: 00, 01, 01, 10, 01, 10, 10, 11.
REQ-029 WIDTH=1, REG_OUT=1: apply a=1, b=1, cin=0, then one clk edge.
- Required: sum_q=0, cout_q=1, ovf_q=1.
REQ-030 WIDTH=8, REG_OUT=1: apply a=0xFF, b=0x01, cin=0.
- Required: sum=0x00, cout=1 immediately.
- After 1 edge: sum_q=0x00, cout_q=1, ovf_q=0.
REQ-031 WIDTH=8: apply a=0x7F, b=0x00, cin=1.
- Required: sum=0x80, cout=0, ovf_q=1 after 1 edge.
REQ-032 REG_OUT=1: load a nonzero result, then assert rst for 1 edge while inputs change to a=1, b=1, cin=1 (WIDTH=1).
- Required: registered outputs = 0 after that edge.
- Required: sum=1, cout=1 throughout.
- First edge after rst drops: cout_q=1, sum_q=1.
REQ-033 Randomised check: 1000 random vectors at WIDTH=16, compared against a + b + cin.
- Comparison: combinational outputs immediately; registered outputs one cycle later.
